alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-high reset: one clock `clk`; reset `Clear`.
REQ-002 Port `clk`  input  1  rising-edge clock; all state changes on it.
REQ-003 Port `Clear`  input  1  synchronous active-high reset.
REQ-004 Port `start`  input  1  request to run one fetch+execute sequence; sampled only in IDLE.
REQ-005 Port `ir`  input  32  datapath IR contents; opcode ir[31:27], Ra ir[26:23], Rb ir[22:19], Rc ir[18:15].
REQ-006 Ports `PCout MARin IncPC Zin Zlowout Zhiout PCin Read MDRin MDRout IRin Yin HIin LOin`  output  1 each  datapath strobes, same meaning as datapath ports of those names.
REQ-007 Port `Rout` / `Rin`  output  1 each  enable of the register selected by `rsel`.
REQ-008 Port `rsel`  output  4  register index for `Rout`/`Rin`; 0 when neither is asserted.
REQ-009 Port `alu_op`  output  5  opcode presented to the ALU; valid whenever `Zin` is asserted in T4, else 0.
REQ-010 Ports `busy`, `done`, `illegal`  output  1 each  sequence active / one-cycle completion pulse / one-cycle bad-opcode pulse.

Function
REQ-011 States SHALL be IDLE, T0, T1, T2, T3, T4, T5, T6; all outputs Moore-decoded from state plus registered opcode/indices.
REQ-012 IDLE: all strobes 0; `start`=1 -> T0 next edge; `start` ignored in every other state.
REQ-013 T0: PCout, MARin, IncPC, Zin asserted.
REQ-014 T1: Zlowout, PCin, Read, MDRin asserted.
REQ-015 T2: MDRout, IRin asserted.
REQ-016 T3: opcode, Ra, Rb, Rc latched from `ir` at T3 entry edge (IR loaded at T2 edge); Rout with rsel=Rb, Yin asserted.
REQ-017 Opcodes: ADD 00011, SUB 00100, SHR 00101, SHL 00110, ROR 00111, ROL 01000, AND 01001, OR 01010, MUL 01111, DIV 10000, NOT 10001, NEG 10010; all others illegal.
REQ-018 Illegal opcode: T3 asserts no strobes and `illegal`=1 for that cycle, next state IDLE; no `done`.
REQ-019 T4, binary ops: Rout rsel=Rc, Zin, alu_op=opcode; unary NOT/NEG: Rout rsel=Rb, Zin, alu_op=opcode.
REQ-020 T5, non-MUL/DIV: Zlowout, Rin rsel=Ra, `done`=1, next state IDLE.
REQ-021 T5, MUL/DIV: Zlowout, LOin; T6: Zhiout, HIin, `done`=1, next state IDLE.
REQ-022 Latency start-to-done SHALL be 6 cycles (7 for MUL/DIV); back-to-back `start` in the cycle after `done` begins T0 one cycle later.
REQ-023 `busy`=1 in T0..T6, 0 in IDLE; Rout and Rin never asserted in the same cycle; at most one bus driver asserted per cycle.

Reset
REQ-024 `Clear`=1 at a clock edge SHALL force IDLE and clear latched opcode/indices, from any state including mid-sequence; all outputs 0 the following cycle.
REQ-025 `Clear` SHALL take priority over `start` on the same edge.

Structure
REQ-026 Opcode constants, state encoding and IR field bit positions SHALL live in a shared package `cpu_pkg` used also by ALU and datapath.
REQ-027 One sub-module `op_decode` (combinational: opcode -> is_binary, is_unary, is_muldiv, is_illegal) SHALL be instantiated; the FSM stays in the top module.

Verification
REQ-028 ADD: ir={00011,R1,R2,R3,...}, start pulse -> T3 rsel=2 Rout Yin; T4 rsel=3 Zin alu_op=00011; T5 rsel=1 Rin, done 6 cycles after start.
REQ-029 NOT: ir opcode 10001, Ra=0, Rb=1 -> T4 Rout rsel=1, alu_op=10001; T5 Rin rsel=0; no Rc access.
REQ-030 MUL: opcode 01111, Rb=4, Rc=5 -> T5 Zlowout+LOin, T6 Zhiout+HIin+done, no Rin asserted.
REQ-031 Illegal opcode 11111 -> illegal=1 in T3, IDLE next cycle, done never asserted, no Yin.
REQ-032 Clear asserted in T4 of an ADD -> all outputs 0 next cycle, busy=0; subsequent start runs full sequence normally.
REQ-033 start held high continuously for two ADDs -> second T0 one cycle after first done; start during busy has no effect.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode constants, sequencer state encoding and IR field positions
package cpu_pkg;

    localparam int IR_W      = 32;
    localparam int OPCODE_W  = 5;
    localparam int REG_W     = 4;

    localparam int IR_OP_LSB = 27;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_LSB = 15;

    typedef logic [OPCODE_W-1:0] opcode_t;
    typedef logic [REG_W-1:0]    reg_idx_t;

    localparam opcode_t OP_ADD = 5'b00011;
    localparam opcode_t OP_SUB = 5'b00100;
    localparam opcode_t OP_SHR = 5'b00101;
    localparam opcode_t OP_SHL = 5'b00110;
    localparam opcode_t OP_ROR = 5'b00111;
    localparam opcode_t OP_ROL = 5'b01000;
    localparam opcode_t OP_AND = 5'b01001;
    localparam opcode_t OP_OR  = 5'b01010;
    localparam opcode_t OP_MUL = 5'b01111;
    localparam opcode_t OP_DIV = 5'b10000;
    localparam opcode_t OP_NOT = 5'b10001;
    localparam opcode_t OP_NEG = 5'b10010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4,
        ST_T4   = 3'd5,
        ST_T5   = 3'd6,
        ST_T6   = 3'd7
    } seq_state_t;

    function automatic opcode_t ir_opcode(input logic [IR_W-1:0] ir);
        return ir[IR_OP_LSB +: OPCODE_W];
    endfunction

    function automatic reg_idx_t ir_field(input logic [IR_W-1:0] ir, input int lsb);
        return ir[lsb +: REG_W];
    endfunction

endpackage

// File: rtl/op_decode.sv
// rtl/op_decode.sv - classifies an opcode into binary, unary, mul/div or illegal
module op_decode
    import cpu_pkg::*;
(
    input  opcode_t opcode,
    output logic    is_binary,
    output logic    is_unary,
    output logic    is_muldiv,
    output logic    is_illegal
);

    always_comb begin
        is_binary  = 1'b0;
        is_unary   = 1'b0;
        is_muldiv  = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR: is_binary = 1'b1;
            OP_MUL, OP_DIV: begin
                is_binary = 1'b1;
                is_muldiv = 1'b1;
            end
            OP_NOT, OP_NEG:                is_unary  = 1'b1;
            default:                       is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - fetch/execute control FSM driving datapath strobes for ALU instructions
module alu_op_sequencer
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                Clear,
    input  logic                start,
    input  logic [IR_W-1:0]     ir,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                Zin,
    output logic                Zlowout,
    output logic                Zhiout,
    output logic                PCin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                HIin,
    output logic                LOin,
    output logic                Rout,
    output logic                Rin,
    output logic [REG_W-1:0]    rsel,
    output logic [OPCODE_W-1:0] alu_op,
    output logic                busy,
    output logic                done,
    output logic                illegal
);

    seq_state_t state;
    opcode_t    opcode_q;
    reg_idx_t   ra_q;
    reg_idx_t   rb_q;
    reg_idx_t   rc_q;

    opcode_t    dec_opcode;
    logic       dec_binary;
    logic       dec_unary;
    logic       dec_muldiv;
    logic       dec_illegal;
    logic       unused_ir;

    assign unused_ir = ^ir[IR_RC_LSB-1:0];

    // Outputs are registered for the state being entered, so the T2->T3 edge
    // must classify the opcode arriving on ir rather than the stale latch.
    assign dec_opcode = (state == ST_T2) ? ir_opcode(ir) : opcode_q;

    op_decode u_op_decode (
        .opcode     (dec_opcode),
        .is_binary  (dec_binary),
        .is_unary   (dec_unary),
        .is_muldiv  (dec_muldiv),
        .is_illegal (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (Clear) begin
            state    <= ST_IDLE;
            opcode_q <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            rc_q     <= '0;
            {PCout, MARin, IncPC, Zin, Zlowout, Zhiout, PCin, Read} <= '0;
            {MDRin, MDRout, IRin, Yin, HIin, LOin, Rout, Rin}       <= '0;
            rsel    <= '0;
            alu_op  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            {PCout, MARin, IncPC, Zin, Zlowout, Zhiout, PCin, Read} <= '0;
            {MDRin, MDRout, IRin, Yin, HIin, LOin, Rout, Rin}       <= '0;
            rsel    <= '0;
            alu_op  <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_T0;
                        PCout <= 1'b1;
                        MARin <= 1'b1;
                        IncPC <= 1'b1;
                        Zin   <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                ST_T0: begin
                    state   <= ST_T1;
                    Zlowout <= 1'b1;
                    PCin    <= 1'b1;
                    Read    <= 1'b1;
                    MDRin   <= 1'b1;
                end
                ST_T1: begin
                    state  <= ST_T2;
                    MDRout <= 1'b1;
                    IRin   <= 1'b1;
                end
                ST_T2: begin
                    state    <= ST_T3;
                    opcode_q <= ir_opcode(ir);
                    ra_q     <= ir_field(ir, IR_RA_LSB);
                    rb_q     <= ir_field(ir, IR_RB_LSB);
                    rc_q     <= ir_field(ir, IR_RC_LSB);
                    if (dec_illegal) begin
                        illegal <= 1'b1;
                    end else begin
                        Rout <= 1'b1;
                        rsel <= ir_field(ir, IR_RB_LSB);
                        Yin  <= 1'b1;
                    end
                end
                ST_T3: begin
                    if (dec_binary || dec_unary) begin
                        state  <= ST_T4;
                        Rout   <= 1'b1;
                        rsel   <= dec_unary ? rb_q : rc_q;
                        Zin    <= 1'b1;
                        alu_op <= opcode_q;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_T4: begin
                    state   <= ST_T5;
                    Zlowout <= 1'b1;
                    if (dec_muldiv) begin
                        LOin <= 1'b1;
                    end else begin
                        Rin  <= 1'b1;
                        rsel <= ra_q;
                        done <= 1'b1;
                    end
                end
                ST_T5: begin
                    if (dec_muldiv) begin
                        state  <= ST_T6;
                        Zhiout <= 1'b1;
                        HIin   <= 1'b1;
                        done   <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        Clear;
    logic        start;
    logic [31:0] ir;
    logic PCout, MARin, IncPC, Zin, Zlowout, Zhiout, PCin, Read;
    logic MDRin, MDRout, IRin, Yin, HIin, LOin, Rout, Rin;
    logic [3:0] rsel;
    logic [4:0] alu_op;
    logic busy, done, illegal;

    typedef struct packed {
        logic busy, done, illegal;
        logic PCout, MARin, IncPC, Zin, Zlowout, Zhiout, PCin, Read;
        logic MDRin, MDRout, IRin, Yin, HIin, LOin, Rout, Rin;
        logic [3:0] rsel;
        logic [4:0] alu_op;
    } outs_t;

    outs_t exp_q[$];
    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk(clk), .Clear(Clear), .start(start), .ir(ir),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin),
        .Zlowout(Zlowout), .Zhiout(Zhiout), .PCin(PCin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .HIin(HIin), .LOin(LOin), .Rout(Rout), .Rin(Rin),
        .rsel(rsel), .alu_op(alu_op), .busy(busy), .done(done), .illegal(illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic outs_t sample();
        outs_t o;
        o.busy = busy; o.done = done; o.illegal = illegal;
        o.PCout = PCout; o.MARin = MARin; o.IncPC = IncPC; o.Zin = Zin;
        o.Zlowout = Zlowout; o.Zhiout = Zhiout; o.PCin = PCin; o.Read = Read;
        o.MDRin = MDRin; o.MDRout = MDRout; o.IRin = IRin; o.Yin = Yin;
        o.HIin = HIin; o.LOin = LOin; o.Rout = Rout; o.Rin = Rin;
        o.rsel = rsel; o.alu_op = alu_op;
        return o;
    endfunction

    function automatic outs_t zero_outs();
        outs_t o;
        o = '0;
        return o;
    endfunction

    // Reference cycle-by-cycle strobe table for one instruction, followed by an IDLE cycle
    function automatic void push_expected(input logic [31:0] instr);
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        logic legal, unary, muldiv;
        outs_t o;
        op = instr[31:27];
        ra = instr[26:23];
        rb = instr[22:19];
        rc = instr[18:15];
        unary  = (op == 5'b10001) || (op == 5'b10010);
        muldiv = (op == 5'b01111) || (op == 5'b10000);
        legal  = unary || muldiv || (op >= 5'b00011 && op <= 5'b01010);

        o = '0; o.busy = 1; o.PCout = 1; o.MARin = 1; o.IncPC = 1; o.Zin = 1;
        exp_q.push_back(o);
        o = '0; o.busy = 1; o.Zlowout = 1; o.PCin = 1; o.Read = 1; o.MDRin = 1;
        exp_q.push_back(o);
        o = '0; o.busy = 1; o.MDRout = 1; o.IRin = 1;
        exp_q.push_back(o);
        if (!legal) begin
            o = '0; o.busy = 1; o.illegal = 1;
            exp_q.push_back(o);
            exp_q.push_back(zero_outs());
            return;
        end
        o = '0; o.busy = 1; o.Rout = 1; o.rsel = rb; o.Yin = 1;
        exp_q.push_back(o);
        o = '0; o.busy = 1; o.Rout = 1; o.rsel = unary ? rb : rc; o.Zin = 1; o.alu_op = op;
        exp_q.push_back(o);
        if (muldiv) begin
            o = '0; o.busy = 1; o.Zlowout = 1; o.LOin = 1;
            exp_q.push_back(o);
            o = '0; o.busy = 1; o.Zhiout = 1; o.HIin = 1; o.done = 1;
            exp_q.push_back(o);
        end else begin
            o = '0; o.busy = 1; o.Zlowout = 1; o.Rin = 1; o.rsel = ra; o.done = 1;
            exp_q.push_back(o);
        end
        exp_q.push_back(zero_outs());
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'h5a5a};
    endfunction

    task automatic test_reset();
        outs_t got;
        Clear = 1'b1; start = 1'b1; ir = mk_ir(5'b00011, 4'd1, 4'd2, 4'd3);
        for (int i = 0; i < 3; i++) begin
            tick();
            got = sample();
            tests_run++;
            if (got !== zero_outs()) begin
                tests_failed++;
                $display("FAIL reset cyc%0d got=%h exp=%h", i, got, zero_outs());
            end
        end
        Clear = 1'b0; start = 1'b0;
        tick();
    endtask

    task automatic test_instr(input string name, input logic [31:0] instr, input int exp_done_at);
        outs_t got, expv;
        int n, done_at;
        ir = instr;
        push_expected(instr);
        n = exp_q.size();
        done_at = -1;
        start = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (i == 0) start = 1'b0;
            got = sample();
            expv = exp_q.pop_front();
            if (got.done === 1'b1 && done_at < 0) done_at = i + 1;
            tests_run++;
            if (got !== expv) begin
                tests_failed++;
                $display("FAIL %s cyc%0d got=%h exp=%h", name, i, got, expv);
            end
        end
        tests_run++;
        if (done_at != exp_done_at) begin
            tests_failed++;
            $display("FAIL %s_latency got=%0d exp=%0d", name, done_at, exp_done_at);
        end
    endtask

    task automatic test_clear_mid();
        outs_t got, expv;
        ir = mk_ir(5'b00011, 4'd1, 4'd2, 4'd3);
        push_expected(ir);
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) start = 1'b0;
            got = sample();
            expv = exp_q.pop_front();
            tests_run++;
            if (got !== expv) begin
                tests_failed++;
                $display("FAIL clear_mid cyc%0d got=%h exp=%h", i, got, expv);
            end
        end
        exp_q.delete();
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        got = sample();
        tests_run++;
        if (got !== zero_outs()) begin
            tests_failed++;
            $display("FAIL clear_mid_outs got=%h exp=%h", got, zero_outs());
        end
        tick();
        test_instr("after_clear_add", mk_ir(5'b00011, 4'd6, 4'd7, 4'd8), 6);
    endtask

    task automatic test_back_to_back();
        outs_t got, expv;
        int n, first_done, second_t0;
        ir = mk_ir(5'b00011, 4'd9, 4'd10, 4'd11);
        push_expected(ir);
        push_expected(ir);
        n = exp_q.size();
        first_done = -1;
        second_t0 = -1;
        start = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            got = sample();
            if (got.done === 1'b1 && first_done < 0) first_done = i;
            if (first_done >= 0 && i > first_done && got.PCout === 1'b1 && second_t0 < 0) begin
                second_t0 = i;
                start = 1'b0;
            end
            expv = exp_q.pop_front();
            tests_run++;
            if (got !== expv) begin
                tests_failed++;
                $display("FAIL back_to_back cyc%0d got=%h exp=%h", i, got, expv);
            end
        end
        start = 1'b0;
        tests_run++;
        if (second_t0 - first_done != 2 || first_done != 5) begin
            tests_failed++;
            $display("FAIL back_to_back_gap got done=%0d t0=%0d exp done=5 t0=7", first_done, second_t0);
        end
    endtask

    task automatic test_random_ops();
        logic [4:0] op;
        int exp_done;
        for (int k = 0; k < 8; k++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'b01111 || op == 5'b10000) exp_done = 7;
            else if (op == 5'b10001 || op == 5'b10010 || (op >= 5'b00011 && op <= 5'b01010)) exp_done = 6;
            else exp_done = -1;
            test_instr("random_op", mk_ir(op, 4'($urandom), 4'($urandom), 4'($urandom)), exp_done);
        end
    endtask

    initial begin
        Clear = 1'b0; start = 1'b0; ir = '0;
        test_reset();
        test_instr("add", mk_ir(5'b00011, 4'd1, 4'd2, 4'd3), 6);
        test_instr("not", mk_ir(5'b10001, 4'd0, 4'd1, 4'd7), 6);
        test_instr("mul", mk_ir(5'b01111, 4'd2, 4'd4, 4'd5), 7);
        test_instr("div", mk_ir(5'b10000, 4'd15, 4'd14, 4'd13), 7);
        test_instr("neg", mk_ir(5'b10010, 4'd12, 4'd3, 4'd9), 6);
        test_instr("illegal", mk_ir(5'b11111, 4'd1, 4'd2, 4'd3), -1);
        test_instr("illegal_zero", mk_ir(5'b00000, 4'd4, 4'd5, 4'd6), -1);
        test_instr("or", mk_ir(5'b01010, 4'd8, 4'd0, 4'd15), 6);
        test_clear_mid();
        test_back_to_back();
        test_random_ops();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
